flit_rx_assembler: RTL and testbench

Receive-side stage between the byte-level link receiver and the packet router core. Collects a stream of bytes into fixed-size flits and validates the per-flit checksum. Good flits are buffered in a small FIFO and presented to the router on a valid/ready interface. Bad, timed-out and overflowed flits are dropped and flagged with single-cycle error pulses.

---
 rtl/flit_rx_assembler_if.sv | 29 ++
 rtl/flit_rx_assembler.sv | 161 ++++++++++++++++
 tb/tb_flit_rx_assembler.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flit_rx_assembler_if.sv
// Signal bundle between the byte link receiver, flit_rx_assembler and the router core.
// Handshake: a flit transfers on any rising edge with flit_valid && flit_ready; flit_out holds while flit_valid is high and no transfer occurs; rx_valid has no backpressure.
interface flit_rx_assembler_if #(
    parameter int BYTES_PER_FLIT = 8,
    parameter int FIFO_DEPTH     = 4
);
    localparam int FW = 8 * BYTES_PER_FLIT;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [FW-1:0] flit_out;
    logic          flit_valid;
    logic          flit_ready;
    logic [CW-1:0] fifo_count;
    logic          checksum_err;
    logic          overflow_err;
    logic          timeout_err;

    modport master (
        output rx_data, rx_valid, flit_ready,
        input  flit_out, flit_valid, fifo_count, checksum_err, overflow_err, timeout_err
    );

    modport slave (
        input  rx_data, rx_valid, flit_ready,
        output flit_out, flit_valid, fifo_count, checksum_err, overflow_err, timeout_err
    );
endinterface

// File: rtl/flit_rx_assembler.sv
// Assembles received bytes into checksummed flits and queues good ones for the router.
// Bad, overflowed and timed-out flits are dropped with a one-cycle error pulse.
module flit_rx_assembler #(
    parameter int BYTES_PER_FLIT = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    flit_rx_assembler_if.slave   bus_io,
    output logic                 dbg_state_o
);
    localparam int FW = 8 * BYTES_PER_FLIT;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BYTES_PER_FLIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        IDLE     = 1'b0,
        ASSEMBLE = 1'b1
    } state_e;

    state_e        state_q;
    logic [BW-1:0] cnt_q;
    logic [7:0]    sum_q;
    logic [TW-1:0] tmo_q;
    // Holds every byte except the last; the checksum byte goes straight into the FIFO word.
    logic [FW-9:0] hold_q;
    logic          chk_err_q;
    logic          ovf_err_q;
    logic          tmo_err_q;

    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          last_byte;
    logic [7:0]    sum_final;
    logic          flit_good;
    logic          pop;
    logic          room;
    logic          push;
    logic          tmo_fire;
    logic [FW-1:0] push_word;

    always_comb begin
        last_byte = (state_q == ASSEMBLE) && bus_io.rx_valid &&
                    (cnt_q == BW'(BYTES_PER_FLIT - 1));
        sum_final = sum_q + bus_io.rx_data;
        flit_good = (sum_final == 8'h00);
        pop       = (count_q != '0) && bus_io.flit_ready;
        // A full FIFO still has room when its head leaves on the same edge.
        room      = (count_q != CW'(FIFO_DEPTH)) || pop;
        push      = last_byte && flit_good && room;
        tmo_fire  = (state_q == ASSEMBLE) && !bus_io.rx_valid &&
                    (tmo_q == TW'(TIMEOUT_CYCLES - 1));
        push_word = {hold_q, bus_io.rx_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sum_q     <= 8'h00;
            tmo_q     <= '0;
            hold_q    <= '0;
            chk_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            chk_err_q <= last_byte && !flit_good;
            ovf_err_q <= last_byte && flit_good && !room;
            tmo_err_q <= tmo_fire;
            case (state_q)
                IDLE: begin
                    if (bus_io.rx_valid) begin
                        hold_q[FW-9 -: 8] <= bus_io.rx_data;
                        sum_q             <= bus_io.rx_data;
                        cnt_q             <= BW'(1);
                        tmo_q             <= '0;
                        state_q           <= ASSEMBLE;
                    end
                end
                ASSEMBLE: begin
                    if (bus_io.rx_valid) begin
                        for (int i = 0; i < BYTES_PER_FLIT - 1; i++) begin
                            if (cnt_q == BW'(i)) begin
                                hold_q[(BYTES_PER_FLIT - 2 - i) * 8 +: 8] <= bus_io.rx_data;
                            end
                        end
                        sum_q <= sum_final;
                        tmo_q <= '0;
                        if (last_byte) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + BW'(1);
                        end
                    end else if (tmo_fire) begin
                        cnt_q   <= '0;
                        sum_q   <= 8'h00;
                        tmo_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the output mux below hides stale entries while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign bus_io.flit_valid   = (count_q != '0);
    assign bus_io.flit_out     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus_io.fifo_count   = count_q;
    assign bus_io.checksum_err = chk_err_q;
    assign bus_io.overflow_err = ovf_err_q;
    assign bus_io.timeout_err  = tmo_err_q;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_flit_rx_assembler.sv
// Bench for flit_rx_assembler: directed scenarios plus a random byte stream,
// checked against a queue-level model of flit assembly and the output FIFO.
module tb_flit_rx_assembler;
    localparam int BPF   = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 1024;
    localparam int FW    = 8 * BPF;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg_state;

    flit_rx_assembler_if #(.BYTES_PER_FLIT(BPF), .FIFO_DEPTH(DEPTH)) bus ();

    flit_rx_assembler #(
        .BYTES_PER_FLIT(BPF),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_io(bus),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: accepted flits waiting for the router, partial flit bytes, idle gap.
    logic [FW-1:0] exp_q[$];
    logic [7:0]    m_part[$];
    int            m_idle = 0;
    logic          m_chk = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_tmo = 1'b0;

    function automatic logic [FW-1:0] make_flit(input bit good);
        logic [FW-1:0] w;
        logic [7:0]    s;
        logic [7:0]    b;
        w = '0;
        s = 8'h00;
        for (int i = 0; i < BPF - 1; i++) begin
            b = 8'($urandom_range(0, 255));
            s = s + b;
            w = {w[FW-9:0], b};
        end
        b = 8'h00 - s;
        if (!good) b = b + 8'($urandom_range(1, 255));
        return {w[FW-9:0], b};
    endfunction

    function automatic logic [FW-1:0] m_head();
        if (exp_q.size() != 0) return exp_q[0];
        return '0;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_part.delete();
        m_idle = 0;
        m_chk  = 1'b0;
        m_ovf  = 1'b0;
        m_tmo  = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
        bit            popping;
        bit            do_push;
        logic [FW-1:0] w;
        logic [7:0]    s;
        popping = (exp_q.size() != 0) && r;
        do_push = 1'b0;
        w = '0;
        s = 8'h00;
        m_chk = 1'b0;
        m_ovf = 1'b0;
        m_tmo = 1'b0;
        if (v) begin
            m_part.push_back(d);
            m_idle = 0;
            if (m_part.size() == BPF) begin
                foreach (m_part[i]) begin
                    s = s + m_part[i];
                    w = {w[FW-9:0], m_part[i]};
                end
                m_part.delete();
                if (s != 8'h00) m_chk = 1'b1;
                else if (exp_q.size() - int'(popping) < DEPTH) do_push = 1'b1;
                else m_ovf = 1'b1;
            end
        end else if (m_part.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_part.delete();
                m_idle = 0;
                m_tmo  = 1'b1;
            end
        end
        if (popping) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(w);
    endtask

    // Drive one cycle at the falling edge; returns at the next falling edge.
    task automatic tick(input logic v, input logic [7:0] d, input logic r);
        bus.rx_valid   = v;
        bus.rx_data    = d;
        bus.flit_ready = r;
        model_edge(v, d, r);
        @(negedge clk);
    endtask

    task automatic send_flit(input logic [FW-1:0] f, input logic r_last, input logic r_rest);
        logic [FW-1:0] t;
        t = f;
        for (int i = 0; i < BPF; i++) begin
            tick(1'b1, t[FW-1 -: 8], (i == BPF - 1) ? r_last : r_rest);
            t = t << 8;
        end
    endtask

    task automatic test_reset();
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.flit_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.flit_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b want 0", bus.flit_valid);
        end
        n_checks++;
        if (bus.flit_out !== '0) begin
            n_errors++; $display("FAIL reset_out: got %h want 0", bus.flit_out);
        end
        n_checks++;
        if (bus.fifo_count !== '0) begin
            n_errors++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count);
        end
        n_checks++;
        if ({bus.checksum_err, bus.overflow_err, bus.timeout_err} !== 3'b000) begin
            n_errors++; $display("FAIL reset_errs: got %b want 000",
                                 {bus.checksum_err, bus.overflow_err, bus.timeout_err});
        end
        n_checks++;
        if (dbg_state !== 1'b0) begin
            n_errors++; $display("FAIL reset_state: got %b want 0", dbg_state);
        end
        rst = 1'b0;
        model_reset();
        tick(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (bus.fifo_count !== '0 || bus.flit_valid !== 1'b0) begin
            n_errors++; $display("FAIL ready_on_empty: got count %0d valid %b want 0 0",
                                 bus.fifo_count, bus.flit_valid);
        end
    endtask

    task automatic test_single_flit();
        logic [7:0] b[BPF];
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hE4};
        for (int i = 0; i < BPF; i++) begin
            tick(1'b1, b[i], 1'b1);
            if (i < BPF - 1) begin
                n_checks++;
                if (bus.flit_valid !== 1'b0) begin
                    n_errors++; $display("FAIL single_early_valid: byte %0d got %b want 0", i, bus.flit_valid);
                end
            end
        end
        n_checks++;
        if (bus.flit_valid !== 1'b1) begin
            n_errors++; $display("FAIL single_valid: got %b want 1", bus.flit_valid);
        end
        n_checks++;
        if (bus.flit_out !== 64'h01020304050607E4) begin
            n_errors++; $display("FAIL single_out: got %h want 01020304050607e4", bus.flit_out);
        end
        n_checks++;
        if (bus.flit_out !== m_head()) begin
            n_errors++; $display("FAIL single_model: got %h want %h", bus.flit_out, m_head());
        end
        n_checks++;
        if (bus.fifo_count !== CW'(1)) begin
            n_errors++; $display("FAIL single_count1: got %0d want 1", bus.fifo_count);
        end
        n_checks++;
        if ({bus.checksum_err, bus.overflow_err, bus.timeout_err} !== 3'b000) begin
            n_errors++; $display("FAIL single_errs: got %b want 000",
                                 {bus.checksum_err, bus.overflow_err, bus.timeout_err});
        end
        tick(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (bus.flit_valid !== 1'b0 || bus.fifo_count !== '0) begin
            n_errors++; $display("FAIL single_drain: got valid %b count %0d want 0 0",
                                 bus.flit_valid, bus.fifo_count);
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] b[BPF];
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hE5};
        for (int i = 0; i < BPF; i++) tick(1'b1, b[i], 1'b1);
        n_checks++;
        if ({bus.checksum_err, bus.overflow_err, bus.timeout_err} !== 3'b100) begin
            n_errors++; $display("FAIL bad_pulse: got %b want 100",
                                 {bus.checksum_err, bus.overflow_err, bus.timeout_err});
        end
        n_checks++;
        if (bus.flit_valid !== 1'b0 || bus.fifo_count !== '0) begin
            n_errors++; $display("FAIL bad_not_pushed: got valid %b count %0d want 0 0",
                                 bus.flit_valid, bus.fifo_count);
        end
        tick(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (bus.checksum_err !== 1'b0) begin
            n_errors++; $display("FAIL bad_one_cycle: got %b want 0", bus.checksum_err);
        end
    endtask

    task automatic test_overflow();
        logic [FW-1:0] f[5];
        for (int k = 0; k < 5; k++) begin
            f[k] = make_flit(1'b1);
            repeat ($urandom_range(0, 2)) tick(1'b0, 8'h00, 1'b0);
            send_flit(f[k], 1'b0, 1'b0);
            n_checks++;
            if (bus.overflow_err !== (k == 4)) begin
                n_errors++; $display("FAIL ovf_pulse: flit %0d got %b want %b", k, bus.overflow_err, k == 4);
            end
            n_checks++;
            if (bus.fifo_count !== CW'((k < DEPTH) ? k + 1 : DEPTH)) begin
                n_errors++; $display("FAIL ovf_count: flit %0d got %0d want %0d", k, bus.fifo_count,
                                     (k < DEPTH) ? k + 1 : DEPTH);
            end
        end
        tick(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (bus.overflow_err !== 1'b0) begin
            n_errors++; $display("FAIL ovf_one_cycle: got %b want 0", bus.overflow_err);
        end
        for (int k = 0; k < DEPTH; k++) begin
            n_checks++;
            if (bus.flit_valid !== 1'b1 || bus.flit_out !== f[k]) begin
                n_errors++; $display("FAIL ovf_drain: entry %0d got valid %b data %h want 1 %h",
                                     k, bus.flit_valid, bus.flit_out, f[k]);
            end
            tick(1'b0, 8'h00, 1'b1);
        end
        n_checks++;
        if (bus.flit_valid !== 1'b0 || bus.fifo_count !== '0) begin
            n_errors++; $display("FAIL ovf_empty: got valid %b count %0d want 0 0",
                                 bus.flit_valid, bus.fifo_count);
        end
    endtask

    task automatic test_full_pop();
        logic [FW-1:0] f[5];
        for (int k = 0; k < 5; k++) f[k] = make_flit(1'b1);
        for (int k = 0; k < DEPTH; k++) send_flit(f[k], 1'b0, 1'b0);
        n_checks++;
        if (bus.fifo_count !== CW'(DEPTH)) begin
            n_errors++; $display("FAIL full_count: got %0d want %0d", bus.fifo_count, DEPTH);
        end
        send_flit(f[4], 1'b1, 1'b0);
        n_checks++;
        if (bus.overflow_err !== 1'b0) begin
            n_errors++; $display("FAIL full_pop_ovf: got %b want 0", bus.overflow_err);
        end
        n_checks++;
        if (bus.fifo_count !== CW'(DEPTH)) begin
            n_errors++; $display("FAIL full_pop_count: got %0d want %0d", bus.fifo_count, DEPTH);
        end
        for (int k = 1; k < 5; k++) begin
            n_checks++;
            if (bus.flit_valid !== 1'b1 || bus.flit_out !== f[k]) begin
                n_errors++; $display("FAIL full_pop_drain: entry %0d got valid %b data %h want 1 %h",
                                     k, bus.flit_valid, bus.flit_out, f[k]);
            end
            tick(1'b0, 8'h00, 1'b1);
        end
        n_checks++;
        if (bus.fifo_count !== '0) begin
            n_errors++; $display("FAIL full_pop_empty: got %0d want 0", bus.fifo_count);
        end
    endtask

    task automatic test_timeout();
        logic [FW-1:0] g;
        int pulse_at;
        int n_pulse;
        pulse_at = -1;
        n_pulse  = 0;
        for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom_range(0, 255)), 1'b1);
        for (int j = 1; j <= TMO + 8; j++) begin
            tick(1'b0, 8'h00, 1'b1);
            n_checks++;
            if (bus.timeout_err !== m_tmo) begin
                n_errors++; $display("FAIL tmo_model: idle %0d got %b want %b", j, bus.timeout_err, m_tmo);
            end
            if (bus.timeout_err === 1'b1) begin
                n_pulse++;
                pulse_at = j;
            end
        end
        n_checks++;
        if (n_pulse != 1 || pulse_at != TMO) begin
            n_errors++; $display("FAIL tmo_pulse: got %0d pulses at idle %0d want 1 at %0d",
                                 n_pulse, pulse_at, TMO);
        end
        n_checks++;
        if (dbg_state !== 1'b0) begin
            n_errors++; $display("FAIL tmo_state: got %b want 0", dbg_state);
        end
        g = make_flit(1'b1);
        send_flit(g, 1'b1, 1'b1);
        n_checks++;
        if (bus.flit_valid !== 1'b1 || bus.flit_out !== g) begin
            n_errors++; $display("FAIL tmo_next_flit: got valid %b data %h want 1 %h",
                                 bus.flit_valid, bus.flit_out, g);
        end
        tick(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_midflit();
        logic [FW-1:0] g;
        logic [FW-1:0] t;
        send_flit(make_flit(1'b1), 1'b0, 1'b0);
        send_flit(make_flit(1'b1), 1'b0, 1'b0);
        n_checks++;
        if (bus.fifo_count !== CW'(2)) begin
            n_errors++; $display("FAIL rstmid_count: got %0d want 2", bus.fifo_count);
        end
        t = make_flit(1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, t[FW-1 -: 8], 1'b0);
            t = t << 8;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.flit_valid !== 1'b0 || bus.flit_out !== '0 || bus.fifo_count !== '0) begin
            n_errors++; $display("FAIL rstmid_outputs: got valid %b data %h count %0d want 0 0 0",
                                 bus.flit_valid, bus.flit_out, bus.fifo_count);
        end
        n_checks++;
        if ({bus.checksum_err, bus.overflow_err, bus.timeout_err, dbg_state} !== 4'b0000) begin
            n_errors++; $display("FAIL rstmid_errs: got %b want 0000",
                                 {bus.checksum_err, bus.overflow_err, bus.timeout_err, dbg_state});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        g = make_flit(1'b1);
        send_flit(g, 1'b0, 1'b0);
        n_checks++;
        if (bus.fifo_count !== CW'(1) || bus.flit_out !== g) begin
            n_errors++; $display("FAIL rstmid_next: got count %0d data %h want 1 %h",
                                 bus.fifo_count, bus.flit_out, g);
        end
        tick(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (bus.fifo_count !== '0 || bus.checksum_err !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_alone: got count %0d chk %b want 0 0",
                                 bus.fifo_count, bus.checksum_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]    stim_q[$];
        logic [FW-1:0] f;
        for (int n = 0; n < 150; n++) begin
            f = make_flit($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) != 0) begin
                repeat ($urandom_range(1, 3)) stim_q.push_back(9'h000);
            end
            for (int i = 0; i < BPF; i++) begin
                if ($urandom_range(0, 7) == 0) stim_q.push_back(9'h000);
                stim_q.push_back({1'b1, f[FW-1 -: 8]});
                f = f << 8;
            end
        end
        foreach (stim_q[k]) begin
            tick(stim_q[k][8], stim_q[k][7:0], 1'($urandom_range(0, 1)));
            n_checks++;
            if (bus.flit_valid !== (exp_q.size() != 0) || bus.flit_out !== m_head()) begin
                n_errors++; $display("FAIL rand_head: cycle %0d got valid %b data %h want %b %h",
                                     k, bus.flit_valid, bus.flit_out, exp_q.size() != 0, m_head());
            end
            n_checks++;
            if (bus.fifo_count !== CW'(exp_q.size())) begin
                n_errors++; $display("FAIL rand_count: cycle %0d got %0d want %0d",
                                     k, bus.fifo_count, exp_q.size());
            end
            n_checks++;
            if ({bus.checksum_err, bus.overflow_err, bus.timeout_err} !== {m_chk, m_ovf, m_tmo}) begin
                n_errors++; $display("FAIL rand_errs: cycle %0d got %b want %b", k,
                                     {bus.checksum_err, bus.overflow_err, bus.timeout_err},
                                     {m_chk, m_ovf, m_tmo});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_bad_checksum();
        test_overflow();
        test_full_pop();
        test_timeout();
        test_reset_midflit();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit, got unfinished want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
